// File: rtl/nvram_upload_pkg.sv
// Shared types and constants for the NVRAM/hiscore upload reader.
package nvram_upload_pkg;

  localparam int unsigned IOCTL_ADDR_W  = 25;
  localparam int unsigned LAT_W         = 3;
  localparam logic [7:0]  FILL_BYTE     = 8'hFF;
  localparam logic [7:0]  UPL_INDEX_DEF = 8'd4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PAUSE,
    ISSUE,
    LATENCY,
    DONE
  } state_t;

endpackage

// File: rtl/nvram_dirty_tracker.sv
// Tracks whether the NVRAM region has unsaved writes and raises a one-cycle
// autosave upload request on each OSD-open edge while the region is dirty.
module nvram_dirty_tracker (
  input  logic clk,
  input  logic I_RESETn,
  input  logic sel,
  input  logic ioctl_upload,
  input  logic dirty_set,
  input  logic autosave,
  input  logic osd_open,
  output logic ioctl_upload_req
);

  logic dirty;
  logic sess_q;
  logic osd_q;
  logic session_end;
  logic osd_rise;

  // A selected session ends when the upload flag drops after sel was seen.
  assign session_end = sess_q & ~ioctl_upload;
  assign osd_rise    = osd_open & ~osd_q;

  always_ff @(posedge clk or negedge I_RESETn) begin
    if (!I_RESETn) begin
      dirty            <= 1'b0;
      sess_q           <= 1'b0;
      osd_q            <= 1'b0;
      ioctl_upload_req <= 1'b0;
    end else begin
      sess_q           <= sel | (sess_q & ioctl_upload);
      // A new write landing on the clearing cycle must not be lost.
      dirty            <= dirty_set | (dirty & ~session_end);
      osd_q            <= osd_open;
      ioctl_upload_req <= osd_rise & autosave & dirty & ~ioctl_upload;
    end
  end

endmodule

// File: rtl/nvram_upload_reader.sv
// Serves HPS upload reads of the NVRAM region: pauses the CPU, fetches one
// byte per read strobe through the shared RAM port and holds the HPS with wait.
module nvram_upload_reader
  import nvram_upload_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned LEN_W     = 10,
  parameter int unsigned RAM_LAT   = 2,
  parameter logic [7:0]  UPL_INDEX = UPL_INDEX_DEF
) (
  input  logic                    clk,
  input  logic                    I_RESETn,
  input  logic                    ioctl_upload,
  input  logic                    ioctl_rd,
  input  logic [7:0]              ioctl_index,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  output logic [7:0]              ioctl_din,
  output logic                    ioctl_wait,
  output logic                    ioctl_upload_req,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [LEN_W-1:0]        length,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_rd,
  input  logic [7:0]              mem_din,
  output logic                    pause_req,
  input  logic                    paused,
  input  logic                    dirty_set,
  input  logic                    autosave,
  input  logic                    osd_open
);

  localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(RAM_LAT - 1);
  localparam logic             SINGLE_LAT = (RAM_LAT <= 1);

  state_t             state;
  state_t             state_nxt;
  logic [LAT_W-1:0]   lat_cnt;
  logic [LAT_W-1:0]   lat_cnt_nxt;
  logic [7:0]         din_nxt;
  logic [ADDR_W-1:0]  mem_addr_nxt;
  logic               mem_rd_nxt;
  logic               pause_nxt;

  logic sel;
  logic accept;
  logic in_range;
  logic lat_last;

  assign sel      = ioctl_upload & (ioctl_index == UPL_INDEX) & (length != '0);
  assign accept   = sel & ioctl_rd & (state == IDLE);
  assign in_range = ioctl_addr < IOCTL_ADDR_W'(length);
  assign lat_last = lat_cnt <= LAT_W'(1);

  // Wait must already be high in the strobe cycle itself.
  assign ioctl_wait = accept | (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge I_RESETn) begin
    if (!I_RESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = in_range ? WAIT_PAUSE : DONE;
        end
      end
      WAIT_PAUSE: begin
        if (paused) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = SINGLE_LAT ? DONE : LATENCY;
      end
      LATENCY: begin
        if (lat_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    din_nxt      = ioctl_din;
    mem_addr_nxt = mem_addr;
    mem_rd_nxt   = 1'b0;
    lat_cnt_nxt  = lat_cnt;
    // Hold the CPU until the session is over and any fetch in flight is done.
    pause_nxt    = sel | (pause_req & (ioctl_upload | (state != IDLE)));
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_range) begin
            mem_addr_nxt = base_addr + ADDR_W'(ioctl_addr[LEN_W-1:0]);
          end else begin
            din_nxt = FILL_BYTE;
          end
        end
      end
      WAIT_PAUSE: begin
        mem_rd_nxt = paused;
      end
      ISSUE: begin
        lat_cnt_nxt = LAT_LOAD;
        if (SINGLE_LAT) begin
          din_nxt = mem_din;
        end
      end
      LATENCY: begin
        lat_cnt_nxt = lat_last ? '0 : (lat_cnt - LAT_W'(1));
        if (lat_last) begin
          din_nxt = mem_din;
        end
      end
      default: begin
      end
    endcase
  end

  // Registered outputs and latency counter.
  always_ff @(posedge clk or negedge I_RESETn) begin
    if (!I_RESETn) begin
      ioctl_din <= '0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      pause_req <= 1'b0;
      lat_cnt   <= '0;
    end else begin
      ioctl_din <= din_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_rd    <= mem_rd_nxt;
      pause_req <= pause_nxt;
      lat_cnt   <= lat_cnt_nxt;
    end
  end

  nvram_dirty_tracker u_dirty (
    .clk              (clk),
    .I_RESETn         (I_RESETn),
    .sel              (sel),
    .ioctl_upload     (ioctl_upload),
    .dirty_set        (dirty_set),
    .autosave         (autosave),
    .osd_open         (osd_open),
    .ioctl_upload_req (ioctl_upload_req)
  );

endmodule

// File: tb/tb_nvram_upload_reader.sv
// Randomized self-checking bench for nvram_upload_reader with a byte-level
// reference model of region reads, CPU pause handshake and autosave requests.
module tb_nvram_upload_reader;

  localparam int RAM_LAT = 2;

  logic        clk = 1'b0;
  logic        I_RESETn = 1'b1;
  logic        ioctl_upload = 1'b0;
  logic        ioctl_rd = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        ioctl_upload_req;
  logic [15:0] base_addr = '0;
  logic [9:0]  length = '0;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_din;
  logic        pause_req;
  logic        paused = 1'b1;
  logic        dirty_set = 1'b0;
  logic        autosave = 1'b0;
  logic        osd_open = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nvram_upload_reader #(
    .ADDR_W(16), .LEN_W(10), .RAM_LAT(RAM_LAT), .UPL_INDEX(8'd4)
  ) dut (
    .clk(clk), .I_RESETn(I_RESETn), .ioctl_upload(ioctl_upload),
    .ioctl_rd(ioctl_rd), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .ioctl_upload_req(ioctl_upload_req), .base_addr(base_addr),
    .length(length), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_din(mem_din),
    .pause_req(pause_req), .paused(paused), .dirty_set(dirty_set),
    .autosave(autosave), .osd_open(osd_open)
  );

  // RAM model: returns the low address byte once RAM_LAT cycles have elapsed.
  int since_rd = 100;
  always @(posedge clk) begin
    if (mem_rd) since_rd <= 1;
    else if (since_rd < 100) since_rd <= since_rd + 1;
  end
  assign mem_din = ((RAM_LAT == 1) || (!mem_rd && since_rd >= RAM_LAT - 1))
                   ? mem_addr[7:0] : 8'hEE;

  // Event monitors; tasks look at deltas of these totals.
  int          rd_total = 0;
  int          req_total = 0;
  logic [15:0] rd_addr_last = '0;
  always @(negedge clk) begin
    if (mem_rd) begin
      rd_total     <= rd_total + 1;
      rd_addr_last <= mem_addr;
    end
    if (ioctl_upload_req) req_total <= req_total + 1;
  end

  // Results of the last do_read call.
  int          r_wait, r_nrd, r_pre;
  logic [7:0]  r_din;
  logic [15:0] r_raddr;
  logic        r_pr_rel, r_pr_end;

  function automatic logic [15:0] exp_addr(input logic [15:0] b, input logic [24:0] a);
    logic [15:0] off;
    off = {6'd0, a[9:0]};
    return b + off;
  endfunction

  function automatic int exp_wait(input bit inr, input int k);
    if (!inr) return 2;
    return 4 + ((k < 1) ? 1 : k);
  endfunction

  task automatic do_read(input logic [24:0] addr, input int pause_at,
                         input int dup_at, input int drop_at);
    int  r0;
    bit  done;
    r0 = rd_total; r_wait = 0; r_pre = 0; r_pr_rel = 1'b0; done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      ioctl_rd   = (i == 0) || (i == dup_at);
      ioctl_addr = (i == dup_at) ? (addr ^ 25'd1) : addr;
      if (i == drop_at) ioctl_upload = 1'b0;
      #1;
      if (i == pause_at) begin
        r_pre = rd_total - r0; r_pr_rel = pause_req; paused = 1'b1;
      end
      if (!ioctl_wait) done = 1'b1;
      else r_wait++;
    end
    ioctl_rd = 1'b0;
    r_pr_end = pause_req; r_din = ioctl_din;
    r_nrd = rd_total - r0; r_raddr = rd_addr_last;
    checks++;
    if (!done) begin failures++; $display("FAIL read_timeout addr=%h wait stuck high", addr); end
  endtask

  task automatic osd_edge(output int n);
    int q0;
    q0 = req_total;
    @(negedge clk); osd_open = 1'b1;
    repeat (4) @(negedge clk);
    osd_open = 1'b0;
    @(negedge clk); #1;
    n = req_total - q0;
  endtask

  task automatic set_session(input logic up, input logic [7:0] idx);
    @(negedge clk); ioctl_upload = up; ioctl_index = idx;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    #2 I_RESETn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (ioctl_din !== 8'h00) begin failures++; $display("FAIL reset_din got=%h exp=00", ioctl_din); end
    checks++; if (ioctl_wait !== 1'b0) begin failures++; $display("FAIL reset_wait got=%b exp=0", ioctl_wait); end
    checks++; if (ioctl_upload_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", ioctl_upload_req); end
    checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr); end
    checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL reset_mem_rd got=%b exp=0", mem_rd); end
    checks++; if (pause_req !== 1'b0) begin failures++; $display("FAIL reset_pause got=%b exp=0", pause_req); end
    @(negedge clk); I_RESETn = 1'b1;
  endtask

  task automatic test_session_start;
    length = 10'd16; base_addr = 16'h6100;
    @(negedge clk); ioctl_upload = 1'b1; ioctl_index = 8'd4; #1;
    checks++; if (pause_req !== 1'b0) begin failures++; $display("FAIL pause_before_edge got=%b exp=0", pause_req); end
    @(negedge clk); #1;
    checks++; if (pause_req !== 1'b1) begin failures++; $display("FAIL pause_after_edge got=%b exp=1", pause_req); end
  endtask

  task automatic test_basic;
    paused = 1'b1;
    do_read(25'd3, 0, -1, -1);
    checks++; if (r_raddr !== 16'h6103) begin failures++; $display("FAIL basic_addr got=%h exp=6103", r_raddr); end
    checks++; if (r_nrd != 1) begin failures++; $display("FAIL basic_rd_pulses got=%0d exp=1", r_nrd); end
    checks++; if (r_din !== 8'h03) begin failures++; $display("FAIL basic_din got=%h exp=03", r_din); end
    checks++; if (r_wait != 3 + RAM_LAT) begin failures++; $display("FAIL basic_wait got=%0d exp=%0d", r_wait, 3 + RAM_LAT); end
    do_read(25'd15, 0, -1, -1);
    checks++; if (r_din !== 8'h0F) begin failures++; $display("FAIL last_byte_din got=%h exp=0f", r_din); end
  endtask

  task automatic test_out_of_range;
    logic [24:0] far_addr;
    do_read(25'd16, 0, -1, -1);
    checks++; if (r_nrd != 0) begin failures++; $display("FAIL oor_rd_pulses got=%0d exp=0", r_nrd); end
    checks++; if (r_din !== 8'hFF) begin failures++; $display("FAIL oor_din got=%h exp=ff", r_din); end
    checks++; if (r_wait != 2) begin failures++; $display("FAIL oor_wait got=%0d exp=2", r_wait); end
    far_addr = 25'h1000003;
    do_read(far_addr, 0, -1, -1);
    checks++; if (r_din !== 8'hFF || r_nrd != 0) begin failures++; $display("FAIL oor_high_bits got din=%h rd=%0d exp din=ff rd=0", r_din, r_nrd); end
  endtask

  task automatic test_pause_stall;
    paused = 1'b0;
    do_read(25'd5, 20, -1, -1);
    checks++; if (r_pre != 0) begin failures++; $display("FAIL stall_early_rd got=%0d exp=0", r_pre); end
    checks++; if (r_pr_rel !== 1'b1) begin failures++; $display("FAIL stall_pause_req got=%b exp=1", r_pr_rel); end
    checks++; if (r_wait != 24) begin failures++; $display("FAIL stall_wait got=%0d exp=24", r_wait); end
    checks++; if (r_din !== 8'h05 || r_nrd != 1) begin failures++; $display("FAIL stall_data got din=%h rd=%0d exp din=05 rd=1", r_din, r_nrd); end
  endtask

  task automatic test_wrap;
    base_addr = 16'hFFFE;
    do_read(25'd3, 0, -1, -1);
    checks++; if (r_raddr !== 16'h0001) begin failures++; $display("FAIL wrap_addr got=%h exp=0001", r_raddr); end
    checks++; if (r_din !== 8'h01) begin failures++; $display("FAIL wrap_din got=%h exp=01", r_din); end
  endtask

  task automatic test_back_to_back;
    base_addr = 16'h6100;
    for (int d = 1; d <= 3; d++) begin
      do_read(25'(8 + d * 2), 0, d, -1);
      checks++;
      if (r_din !== 8'(8 + d * 2) || r_nrd != 1 || r_wait != 5) begin
        failures++;
        $display("FAIL busy_strobe_%0d got din=%h rd=%0d wait=%0d exp din=%h rd=1 wait=5", d, r_din, r_nrd, r_wait, 8'(8 + d * 2));
      end
    end
  endtask

  task automatic test_random;
    logic [24:0] a;
    logic [15:0] ea;
    logic [7:0]  ed;
    bit          inr;
    int          k, dup, ew, en;
    for (int it = 0; it < 40; it++) begin
      base_addr = 16'($urandom);
      length    = 10'($urandom_range(1, 1023));
      case ($urandom_range(0, 3))
        0, 1: a = 25'($urandom_range(0, int'(length) - 1));
        2:    a = 25'($urandom_range(int'(length), 1023));
        default: a = 25'($urandom) | 25'h400;
      endcase
      k = $urandom_range(0, 3);
      paused = (k == 0);
      inr = (a < {15'd0, length});
      dup = inr ? $urandom_range(1, 3) : 1;
      do_read(a, k, dup, -1);
      ea = exp_addr(base_addr, a);
      ed = inr ? ea[7:0] : 8'hFF;
      ew = exp_wait(inr, k);
      en = inr ? 1 : 0;
      checks++;
      if (r_din !== ed || r_wait != ew || r_nrd != en || (inr && r_raddr !== ea)) begin
        failures++;
        $display("FAIL rand_%0d got din=%h wait=%0d rd=%0d addr=%h exp din=%h wait=%0d rd=%0d addr=%h",
                 it, r_din, r_wait, r_nrd, r_raddr, ed, ew, en, ea);
      end
    end
    paused = 1'b1;
  endtask

  task automatic test_upload_drop;
    base_addr = 16'h6100; length = 10'd16;
    do_read(25'd4, 0, -1, 2);
    checks++; if (r_din !== 8'h04 || r_wait != 5) begin failures++; $display("FAIL drop_fetch got din=%h wait=%0d exp din=04 wait=5", r_din, r_wait); end
    checks++; if (r_pr_end !== 1'b1) begin failures++; $display("FAIL drop_pause_hold got=%b exp=1", r_pr_end); end
    @(negedge clk); #1;
    checks++; if (pause_req !== 1'b0) begin failures++; $display("FAIL drop_pause_clear got=%b exp=0", pause_req); end
  endtask

  task automatic test_reset_midop;
    set_session(1'b1, 8'd4);
    do_read(25'd3, 0, -1, -1);
    @(negedge clk); ioctl_addr = 25'd6; ioctl_rd = 1'b1;
    @(negedge clk); ioctl_rd = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ioctl_wait !== 1'b1) begin failures++; $display("FAIL midop_busy got=%b exp=1", ioctl_wait); end
    I_RESETn = 1'b0; #1;
    checks++; if (ioctl_wait !== 1'b0 || mem_rd !== 1'b0) begin failures++; $display("FAIL rst_wait_rd got wait=%b rd=%b exp 0 0", ioctl_wait, mem_rd); end
    checks++; if (pause_req !== 1'b0) begin failures++; $display("FAIL rst_pause got=%b exp=0", pause_req); end
    checks++; if (ioctl_din !== 8'h00) begin failures++; $display("FAIL rst_din got=%h exp=00", ioctl_din); end
    @(negedge clk); I_RESETn = 1'b1;
    repeat (2) @(negedge clk);
    do_read(25'd9, 0, -1, -1);
    checks++;
    if (r_din !== 8'h09 || r_wait != 5 || r_raddr !== 16'h6109) begin
      failures++; $display("FAIL post_rst_read got din=%h wait=%0d addr=%h exp din=09 wait=5 addr=6109", r_din, r_wait, r_raddr);
    end
  endtask

  task automatic test_autosave;
    int n;
    set_session(1'b0, 8'd4);
    autosave = 1'b1;
    @(negedge clk); dirty_set = 1'b1;
    @(negedge clk); dirty_set = 1'b0;
    osd_edge(n);
    checks++; if (n != 1) begin failures++; $display("FAIL autosave_req got=%0d exp=1", n); end
    autosave = 1'b0; osd_edge(n); autosave = 1'b1;
    checks++; if (n != 0) begin failures++; $display("FAIL autosave_off got=%0d exp=0", n); end
    set_session(1'b1, 8'd3); set_session(1'b0, 8'd3);
    osd_edge(n);
    checks++; if (n != 1) begin failures++; $display("FAIL other_index_keeps_dirty got=%0d exp=1", n); end
    set_session(1'b1, 8'd4); set_session(1'b0, 8'd4);
    osd_edge(n);
    checks++; if (n != 0) begin failures++; $display("FAIL dirty_cleared got=%0d exp=0", n); end
    set_session(1'b1, 8'd4);
    @(negedge clk); ioctl_upload = 1'b0; dirty_set = 1'b1;
    @(negedge clk); dirty_set = 1'b0;
    osd_edge(n);
    checks++; if (n != 1) begin failures++; $display("FAIL dirty_set_on_clear got=%0d exp=1", n); end
    set_session(1'b1, 8'd4);
    osd_edge(n);
    checks++; if (n != 0) begin failures++; $display("FAIL req_during_upload got=%0d exp=0", n); end
    set_session(1'b0, 8'd4);
  endtask

  initial begin
    test_reset();
    test_session_start();
    test_basic();
    test_out_of_range();
    test_pause_stall();
    test_wrap();
    test_back_to_back();
    test_random();
    test_upload_drop();
    test_reset_midop();
    test_autosave();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nvram_upload_reader.md
Name: nvram_upload_reader

Overview:
- Serves HPS upload reads (the HPS-bound direction of the ioctl file-transfer interface) for the hiscore/NVRAM region of game RAM.
- On each HPS read strobe it pauses the CPU, fetches one byte through a shared RAM access port, presents it on ioctl_din and holds the HPS off with ioctl_wait until the byte is valid.
- It also raises ioctl_upload_req when the region is dirty and autosave fires.
- It sits beside hps_io in emu and drives the core's hs_address/hs_access bus.

Parameters:
- ADDR_W, 16, game RAM address width.
- LEN_W, 10, width of region byte length.
- RAM_LAT, 2, cycles from mem_rd to valid mem_din (1..7).
- UPL_INDEX, 8'd4, ioctl_index value that selects this block.

Ports:
- clk, in, 1, system clock (clk_sys).
- I_RESETn, in, 1, asynchronous active-low reset.
- ioctl_upload, in, 1, HPS upload session active.
- ioctl_rd, in, 1, one-cycle read strobe for ioctl_addr.
- ioctl_index, in, 8, session file index.
- ioctl_addr, in, 25, byte offset within region.
- ioctl_din, out, 8, byte returned to HPS.
- ioctl_wait, out, 1, HPS must hold off while high.
- ioctl_upload_req, out, 1, one-cycle request for HPS to start an upload.
- base_addr, in, ADDR_W, region start in game RAM.
- length, in, LEN_W, region size in bytes; 0 = disabled.
- mem_addr, out, ADDR_W, RAM access address.
- mem_rd, out, 1, one-cycle read strobe to RAM.
- mem_din, in, 8, RAM read data.
- pause_req, out, 1, request CPU pause.
- paused, in, 1, CPU is paused.
- dirty_set, in, 1, pulse: game wrote into region.
- autosave, in, 1, autosave enabled.
- osd_open, in, 1, OSD visible.

Behaviour:
- Reset values: ioctl_din=0, ioctl_wait=0, ioctl_upload_req=0, mem_addr=0, mem_rd=0, pause_req=0. FSM=IDLE, dirty=0, latency counter=0.
- sel = ioctl_upload & (ioctl_index==UPL_INDEX) & (length!=0).
- Start of session: when sel first goes high, register pause_req=1 on the next edge.
- pause_req stays high until ioctl_upload falls. It then clears on the next edge.
- accept = sel & ioctl_rd & state==IDLE.
- ioctl_wait = accept | (state!=IDLE). It is combinational, so the wait is visible in the strobe cycle.
- FSM states: IDLE, WAIT_PAUSE, ISSUE, LATENCY, DONE.
  - IDLE: on accept with ioctl_addr<length, latch mem_addr = base_addr + ioctl_addr[LEN_W-1:0] (truncated to ADDR_W, wraps mod 2^ADDR_W) and go to WAIT_PAUSE.
  - IDLE: on accept with ioctl_addr>=length (all 25 bits compared), load ioctl_din=8'hFF, issue no mem_rd, and go to DONE.
  - WAIT_PAUSE: stay until paused=1, then go to ISSUE.
  - ISSUE: mem_rd=1 for exactly one cycle, counter=RAM_LAT-1, go to LATENCY.
  - LATENCY: decrement the counter. At 0, capture mem_din into ioctl_din and go to DONE.
  - DONE: one cycle, then IDLE. ioctl_wait is low from the IDLE cycle onward.
- Latency, strobe to wait-low, when already paused: 3+RAM_LAT cycles. With RAM_LAT=2: strobe at T, mem_rd at T+2, capture at T+4, DONE T+4..T+5, wait low at T+5.
- ioctl_rd arriving while state!=IDLE is ignored. The HPS is required to honour wait.
- ioctl_upload falling mid-fetch: the FSM completes the current byte. pause_req drops only once the FSM is back in IDLE.
- ioctl_din holds its last value between reads.
- Dirty tracking:
  - dirty is set by dirty_set.
  - dirty is cleared on the falling edge of a selected session.
  - If dirty_set coincides with that clear, dirty stays 1.
- Autosave: ioctl_upload_req pulses for 1 cycle on the rising edge of osd_open when autosave & dirty & !ioctl_upload. It never pulses twice for one osd_open edge.
- Asynchronous reset mid-operation: return to IDLE immediately and drop all outputs. The HPS read is aborted.

Decomposition:
- Package nvram_upload_pkg: state enum (IDLE, WAIT_PAUSE, ISSUE, LATENCY, DONE), localparam FILL_BYTE=8'hFF, and the UPL_INDEX default.
- Sub-module nvram_dirty_tracker: owns dirty, the osd_open edge detect and the ioctl_upload_req pulse.
- The top holds the FSM and the datapath.

Test Plan:
1. length=16, base=16'h6100, paused tied 1, mem returns addr[7:0]. Rd at addr 3 -> mem_addr=16'h6103, mem_rd single pulse, ioctl_din=8'h03, wait high exactly 5 cycles.
2. Rd at addr 16 with length=16 -> no mem_rd, ioctl_din=8'hFF, wait high 2 cycles.
3. paused held 0 for 20 cycles after session start -> pause_req=1, no mem_rd, wait high throughout. Set paused=1 -> byte returned 4 cycles later.
4. base=16'hFFFE, addr 3 -> mem_addr=16'h0001 (wrap).
5. Set dirty, autosave=1, raise osd_open -> one-cycle ioctl_upload_req. Complete a session -> dirty=0. A second osd_open edge -> no request. dirty_set on the session-end cycle -> dirty stays 1.
6. Assert I_RESETn low during LATENCY -> wait, mem_rd, pause_req and ioctl_din all 0 asynchronously. After release, the next rd is serviced normally.
